// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative multiply/divide unit that owns the architectural HI/LO registers.
//   MULT/MULTU/DIV/DIVU take WIDTH+2 cycles from the accepting edge to the
//   HI/LO update. MTHI/MTLO write HI/LO on the edge that accepts them.
// Ports
//   clk      rising-edge clock
//   rst_b    asynchronous active-low reset
//   start    launch op (only honoured while busy is low)
//   op       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   rs_data  multiplicand / dividend / MTHI-MTLO source
//   rt_data  multiplier / divisor
//   flush    abort the in-flight op, HI/LO keep their values
//   busy     op in flight, core must stall
//   done     one-cycle pulse on the cycle HI/LO carry a new arithmetic result
//   hi, lo   architectural HI/LO
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opd_q, opd_d;      // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;  // negate product / quotient
    logic               neg_b_q, neg_b_d;  // negate remainder
    logic               fix_ph_q, fix_ph_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // One iteration step of each algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_tmp;
    logic [WIDTH-1:0]   div_diff, div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (div_tmp >= {1'b0, opd_q});
        // When div_ge holds the true difference is below 2^WIDTH, so modulo
        // arithmetic on the low bits is exact.
        div_diff = div_tmp[WIDTH-1:0] - opd_q;
        div_rem  = div_ge ? div_diff : div_tmp[WIDTH-1:0];
    end

    always_comb begin
        if (is_div_q) begin
            fix_res[2*WIDTH-1:WIDTH] = neg_b_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fix_res[WIDTH-1:0]       = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else begin
            fix_res = neg_a_q ? -acc_q : acc_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        fix_ph_d = fix_ph_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000: begin
                            acc_d    = {{WIDTH{1'b0}}, mag(rt_data)};
                            opd_d    = mag(rs_data);
                            is_div_d = 1'b0;
                            neg_a_d  = rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                            neg_b_d  = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_RUN;
                        end
                        3'b001: begin
                            acc_d    = {{WIDTH{1'b0}}, rt_data};
                            opd_d    = rs_data;
                            is_div_d = 1'b0;
                            neg_a_d  = 1'b0;
                            neg_b_d  = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_RUN;
                        end
                        3'b010: begin
                            // A zero divisor runs on the raw dividend with no sign
                            // fix-up: the iteration then leaves rem = dividend and
                            // quotient = all ones, which is the required result.
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = S_RUN;
                            if (rt_data == '0) begin
                                acc_d   = {{WIDTH{1'b0}}, rs_data};
                                opd_d   = '0;
                                neg_a_d = 1'b0;
                                neg_b_d = 1'b0;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, mag(rs_data)};
                                opd_d   = mag(rt_data);
                                neg_a_d = rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                                neg_b_d = rs_data[WIDTH-1];
                            end
                        end
                        3'b011: begin
                            acc_d    = {{WIDTH{1'b0}}, rs_data};
                            opd_d    = rt_data;
                            is_div_d = 1'b1;
                            neg_a_d  = 1'b0;
                            neg_b_d  = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_RUN;
                        end
                        3'b100:  hi_d = rs_data;
                        3'b101:  lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST) begin
                    state_d  = S_FIX;
                    fix_ph_d = 1'b0;
                end
            end
            S_FIX: begin
                // Two phases: the first registers the sign-corrected result so
                // the wide negate never sits directly on the HI/LO write path.
                if (!fix_ph_q) begin
                    acc_d    = fix_res;
                    fix_ph_d = 1'b1;
                end else begin
                    hi_d     = acc_q[2*WIDTH-1:WIDTH];
                    lo_d     = acc_q[WIDTH-1:0];
                    done_d   = 1'b1;
                    fix_ph_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything but reset, including an MTHI/MTLO in IDLE.
        if (flush) begin
            state_d  = S_IDLE;
            fix_ph_d = 1'b0;
            done_d   = 1'b0;
            hi_d     = hi_q;
            lo_d     = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            fix_ph_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            fix_ph_q <= fix_ph_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
//   Directed and randomized checks of mips_muldiv_unit against a plain
//   arithmetic reference model of MIPS HI/LO semantics.
module tb_mips_muldiv_unit;
    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: MIPS HI/LO results from ordinary integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        h = '0;
        l = '0;
        case (o)
            3'd0: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                h = sp[63:32];
                l = sp[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                h = up[63:32];
                l = up[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 32'd0;
                    l = 32'h8000_0000;
                end else begin
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called mid-cycle with the unit idle (or on its done cycle). Checks
    // latency, busy and the final HI/LO; garbles the operand inputs after the
    // accepting edge. intrude_at > 0 fires a MULT start while busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int intrude_at);
        logic [31:0] eh, el;
        int lat;
        model(o, a, b, eh, el);
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom_range(0, 7));
        rs_data = $urandom;
        rt_data = $urandom;
        check({tag, " busy"}, 64'(busy), 64'd1);
        lat = 0;
        for (int k = 1; k <= LAT + 6; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k == intrude_at) begin
                start = 1'b1;
                op = 3'd0;
                rs_data = $urandom;
                rt_data = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] v, input string tag);
        start = 1'b1;
        op = o;
        rs_data = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o == 3'd4) model_hi = v;
        else model_lo = v;
        check({tag, " hi"}, 64'(hi), 64'(model_hi));
        check({tag, " lo"}, 64'(lo), 64'(model_lo));
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check({tag, " no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] v;
        // Reset state.
        #3 rst_b = 1'b0;
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases.
        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, "mult_neg", 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, "multu", 0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg", 0);
        run_op(3'd3, 32'h0000_0007, 32'h0000_0002, "divu", 0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        run_op(3'd3, 32'h0000_0007, 32'h0000_0000, "divu_zero", 0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, "div_zero", 0);

        // MTHI / MTLO.
        @(posedge clk);
        #1;
        move_to(3'd4, 32'h1234_5678, "mthi");
        move_to(3'd5, 32'h9ABC_DEF0, "mtlo");

        // Reserved op code has no effect.
        start = 1'b1;
        op = 3'd6;
        rs_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("reserved busy", 64'(busy), 64'd0);
        check("reserved hi", 64'(hi), 64'(model_hi));

        // Start while busy is ignored.
        run_op(3'd0, 32'h0000_0003, 32'hFFFF_FFFB, "busy_start", 5);

        // Flush during RUN.
        move_to(3'd4, 32'hAAAA_5555, "pre_flush");
        start = 1'b1;
        op = 3'd3;
        rs_data = 32'd12345;
        rt_data = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush hi", 64'(hi), 64'(model_hi));
        check("flush lo", 64'(lo), 64'(model_lo));
        expect_no_done("flush", 40);

        // Flush in IDLE cancels a concurrent MTLO.
        start = 1'b1;
        op = 3'd5;
        rs_data = 32'h0BAD_F00D;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_mt lo", 64'(lo), 64'(model_lo));

        // Reset pulse in the middle of RUN.
        start = 1'b1;
        op = 3'd0;
        rs_data = 32'h1234_0000;
        rt_data = 32'h0000_4321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        #2;
        rst_b = 1'b1;
        model_hi = '0;
        model_lo = '0;
        expect_no_done("midreset", 40);

        // Randomized ops, launched back-to-back on each done cycle.
        for (int i = 0; i < 40; i++) begin
            v = rnd_operand();
            run_op(3'($urandom_range(0, 3)), v, rnd_operand(), "rand", 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
